// File: rtl/mode_ctrl_if.sv
// mode_ctrl_if: button/pedal/selector inputs and mode outputs.
// Ports: power, mode_sel, brake (in); mode, powered, mode_changed (out).
interface mode_ctrl_if #(
  parameter int NUM_MODES = 3
);
  localparam int MW = $clog2(NUM_MODES + 1);

  logic                 power;
  logic [NUM_MODES-1:0] mode_sel;
  logic                 brake;
  logic [MW-1:0]        mode;
  logic                 powered;
  logic                 mode_changed;

  modport master (
    output power,
    output mode_sel,
    output brake,
    input  mode,
    input  powered,
    input  mode_changed
  );

  modport slave (
    input  power,
    input  mode_sel,
    input  brake,
    output mode,
    output powered,
    output mode_changed
  );
endinterface

// File: rtl/mode_ctrl.sv
// mode_ctrl: power-hold on/off FSM with braked drive-mode select.
// Ports: clk, rst_n (async low), bus (mode_ctrl_if.slave).
module mode_ctrl #(
  parameter int NUM_MODES    = 3,
  parameter int HOLD_CYCLES  = 100000000,
  parameter int IDLE_CYCLES  = 0,
  parameter int DEFAULT_MODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  mode_ctrl_if.slave bus
);
  localparam int MW = $clog2(NUM_MODES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int IW = (IDLE_CYCLES > 0) ?
                      $clog2(IDLE_CYCLES + 1) : 1;

  localparam logic [HW-1:0] HOLD_LAST =
    HW'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST =
    IW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
  localparam logic [MW-1:0] DEF_MODE =
    MW'(DEFAULT_MODE);
  localparam bit IDLE_EN = (IDLE_CYCLES > 0);

  typedef enum logic [1:0] {
    S_OFF,
    S_ON_WAIT_REL,
    S_ON,
    S_OFF_WAIT_REL
  } state_t;

  state_t        r_state, w_state_nx;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic [IW-1:0] r_idle, w_idle_nx;
  logic [MW-1:0] r_mode, w_mode_nx;
  logic          r_powered, w_powered_nx;
  logic          r_chg, w_chg_nx;

  logic          w_hold_hit;
  logic          w_idle_cond;
  logic          w_idle_hit;
  logic          w_sel_ok;
  logic [MW-1:0] w_sel_mode;

  always_comb begin
    w_sel_mode = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (bus.mode_sel[k]) w_sel_mode = MW'(k + 1);
    end
  end

  assign w_sel_ok    = bus.brake && $onehot(bus.mode_sel);
  assign w_hold_hit  = bus.power && (r_hold == HOLD_LAST);
  assign w_idle_cond = !bus.power && !bus.brake &&
                       (bus.mode_sel == '0);
  assign w_idle_hit  = IDLE_EN && w_idle_cond &&
                       (r_idle == IDLE_LAST);

  // Counters only advance below their last value, so a hit
  // always coincides with a state change that clears them.
  always_comb begin
    w_state_nx   = r_state;
    w_mode_nx    = r_mode;
    w_powered_nx = r_powered;
    w_chg_nx     = 1'b0;
    w_hold_nx    = '0;
    w_idle_nx    = '0;
    unique case (r_state)
      S_OFF: begin
        if (w_hold_hit) begin
          w_state_nx   = S_ON_WAIT_REL;
          w_powered_nx = 1'b1;
          w_mode_nx    = DEF_MODE;
        end else if (bus.power) begin
          w_hold_nx = r_hold + 1'b1;
        end
      end
      S_ON_WAIT_REL: begin
        if (!bus.power) w_state_nx = S_ON;
      end
      S_ON: begin
        if (w_hold_hit) begin
          w_state_nx   = S_OFF_WAIT_REL;
          w_powered_nx = 1'b0;
          w_mode_nx    = '0;
        end else if (w_idle_hit) begin
          w_state_nx   = S_OFF;
          w_powered_nx = 1'b0;
          w_mode_nx    = '0;
        end else begin
          if (bus.power) w_hold_nx = r_hold + 1'b1;
          if (IDLE_EN && w_idle_cond) begin
            w_idle_nx = r_idle + 1'b1;
          end
          if (w_sel_ok) begin
            w_mode_nx = w_sel_mode;
            w_chg_nx  = (w_sel_mode != r_mode);
          end
        end
      end
      S_OFF_WAIT_REL: begin
        if (!bus.power) w_state_nx = S_OFF;
      end
      default: w_state_nx = S_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OFF;
      r_hold    <= '0;
      r_idle    <= '0;
      r_mode    <= '0;
      r_powered <= 1'b0;
      r_chg     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_hold    <= w_hold_nx;
      r_idle    <= w_idle_nx;
      r_mode    <= w_mode_nx;
      r_powered <= w_powered_nx;
      r_chg     <= w_chg_nx;
    end
  end

  assign bus.mode         = r_mode;
  assign bus.powered      = r_powered;
  assign bus.mode_changed = r_chg;
endmodule
